// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one sequential read per cycle to a 1-cycle
// synchronous instruction memory and buffers returned words with their PC for decode.
module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INST_W-1:0]          imem_rdata,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [INST_W-1:0]          inst_data,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc_reg;
    logic              inflight_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [CW-1:0]     count_reg;

    logic [INST_W-1:0] entry_data [DEPTH];
    logic [ADDR_W-1:0] entry_pc   [DEPTH];

    logic [CW:0]       occupancy;
    logic              has_credit;
    logic              push;
    logic              pop;

    // A word already in flight owns a FIFO slot, so the unconditional push never overflows.
    assign occupancy  = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    assign has_credit = occupancy < (CW+1)'(DEPTH);

    // Gating with reset makes the request drop as soon as reset asserts, not at the next edge.
    assign imem_req   = reset & fetch_en & ~redirect_valid & has_credit;
    assign imem_addr  = fetch_pc_reg;

    assign inst_valid = (count_reg != '0) & ~redirect_valid;
    assign push       = inflight_reg & ~redirect_valid;
    assign pop        = inst_valid & inst_ready;

    assign inst_data  = entry_data[rd_ptr_reg];
    assign inst_pc    = entry_pc[rd_ptr_reg];
    assign fifo_count = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [INST_W-1:0] data_reg;
            logic [ADDR_W-1:0] pc_reg;
            logic              write_en;

            assign write_en = push & (wr_ptr_reg == PW'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_reg <= '0;
                    pc_reg   <= '0;
                end else if (write_en) begin
                    data_reg <= imem_rdata;
                    pc_reg   <= inflight_pc_reg;
                end
            end

            assign entry_data[gi] = data_reg;
            assign entry_pc[gi]   = pc_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
        end else if (redirect_valid) begin
            // Redirect wins over issue and pop; the word returning this cycle is dropped.
            fetch_pc_reg <= redirect_pc;
            inflight_reg <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            inflight_reg <= imem_req;
            if (imem_req) begin
                fetch_pc_reg    <= fetch_pc_reg + ADDR_W'(4);
                inflight_pc_reg <= fetch_pc_reg;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
